reg_writeback_ctrl: RTL and testbench

//  Write-side initiator for the 8-bit CPU register file (8 x 8-bit, one write port).

---
 rtl/reg_writeback_ctrl_pkg.sv | 17 +
 rtl/reg_writeback_ctrl_wb_fifo.sv | 73 +++++++
 rtl/reg_writeback_ctrl.sv | 121 ++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared register-file definitions for the writeback path.
// Also defines the FIFO entry layout used between the top level and the FIFO.
package reg_writeback_ctrl_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 8;
  localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

  localparam logic [REG_ADDR_W-1:0] R0_ADDR = 3'b000;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// Writeback FIFO: circular storage with push/pop/count.
// Also reports per-age destination matches; age 0 is the oldest entry.
module wb_fifo
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [ENTRY_W-1:0]        i_push_entry,
  input  logic                      i_pop,
  output logic [ENTRY_W-1:0]        o_head,
  output logic [$clog2(DEPTH):0]    o_count,
  input  logic [REG_ADDR_W-1:0]     i_match_reg,
  output logic [DEPTH-1:0]          o_match_vec,
  output logic [DEPTH*DATA_W-1:0]   o_age_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // Storage carries no reset; validity is tracked purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] w_idx;
      wb_entry_t        w_entry;
      logic             w_valid;

      assign w_idx    = r_rd_ptr + PTR_W'(gi);
      assign w_entry  = r_mem[w_idx];
      assign w_valid  = (CNT_W'(gi) < r_count);
      assign o_match_vec[gi] = w_valid && (w_entry.rd == i_match_reg);
      assign o_age_data[gi*DATA_W +: DATA_W] = w_entry.data;
    end
  endgenerate

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Writeback initiator: arbitrates ALU/load requests into a FIFO, drains one entry
// per cycle onto the register-file write port and forwards pending results to decode.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter bit R0_DISCARD = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_alu_valid,
  input  logic [2:0]             i_alu_reg,
  input  logic [7:0]             i_alu_data,
  output logic                   o_alu_ready,
  input  logic                   i_ld_valid,
  input  logic [2:0]             i_ld_reg,
  input  logic [7:0]             i_ld_data,
  output logic                   o_ld_ready,
  output logic                   o_rf_write_enable,
  output logic [2:0]             o_rf_write_reg,
  output logic [7:0]             o_rf_write_data,
  input  logic [2:0]             i_fwd_reg,
  output logic                   o_fwd_hit,
  output logic [7:0]             o_fwd_data,
  output logic [$clog2(DEPTH):0] o_wb_count,
  output logic                   o_wb_idle
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]        w_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_alu_fire;
  logic                    w_ld_fire;
  logic                    w_discard;
  logic                    w_push;
  logic                    w_pop;
  wb_entry_t               w_push_entry;
  wb_entry_t               w_head;
  logic [DEPTH-1:0]        w_match_vec;
  logic [DEPTH*DATA_W-1:0] w_age_data;
  logic                    w_fwd_hit;
  logic [DATA_W-1:0]       w_fwd_data;

  logic                    r_rf_write_enable;
  logic [REG_ADDR_W-1:0]   r_rf_write_reg;
  logic [DATA_W-1:0]       r_rf_write_data;

  assign w_full  = (w_count == CNT_W'(DEPTH));
  assign w_empty = (w_count == '0);

  // Ready ignores a same-cycle pop so the accept path never depends on the drain.
  assign o_alu_ready = !w_full;
  assign o_ld_ready  = !w_full && !i_alu_valid;

  assign w_alu_fire = i_alu_valid && o_alu_ready;
  assign w_ld_fire  = i_ld_valid && o_ld_ready;

  assign w_push_entry.rd   = w_alu_fire ? i_alu_reg  : i_ld_reg;
  assign w_push_entry.data = w_alu_fire ? i_alu_data : i_ld_data;

  assign w_discard = R0_DISCARD && (w_push_entry.rd == R0_ADDR);
  assign w_push    = (w_alu_fire || w_ld_fire) && !w_discard;
  assign w_pop     = !w_empty;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .i_match_reg  (i_fwd_reg),
    .o_match_vec  (w_match_vec),
    .o_age_data   (w_age_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_write_enable <= 1'b0;
      r_rf_write_reg    <= '0;
      r_rf_write_data   <= '0;
    end else begin
      r_rf_write_enable <= w_pop;
      if (w_pop) begin
        r_rf_write_reg  <= w_head.rd;
        r_rf_write_data <= w_head.data;
      end
    end
  end

  // The write stage is older than every FIFO entry, so it is checked first and any
  // FIFO match overrides it; ascending age order leaves the youngest match in place.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (r_rf_write_enable && (r_rf_write_reg == i_fwd_reg)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = r_rf_write_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match_vec[k]) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_age_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign o_fwd_hit         = w_fwd_hit;
  assign o_fwd_data        = w_fwd_data;
  assign o_rf_write_enable = r_rf_write_enable;
  assign o_rf_write_reg    = r_rf_write_reg;
  assign o_rf_write_data   = r_rf_write_data;
  assign o_wb_count        = w_count;
  assign o_wb_idle         = w_empty && !r_rf_write_enable;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed scenarios then random traffic, all checked
// against a queue-based model of pending writes plus the register-file write stage.
module tb_reg_writeback_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       alu_valid = 1'b0, ld_valid = 1'b0;
  logic [2:0] alu_reg = '0, ld_reg = '0, fwd_reg = '0;
  logic [7:0] alu_data = '0, ld_data = '0;
  logic       alu_ready, ld_ready, rf_we, fwd_hit, wb_idle;
  logic [2:0] rf_reg;
  logic [7:0] rf_data, fwd_data;
  logic [2:0] wb_count;

  logic       z_alu_valid = 1'b0, z_ld_valid = 1'b0;
  logic [2:0] z_alu_reg = '0, z_ld_reg = '0, z_fwd_reg = '0;
  logic [7:0] z_alu_data = '0, z_ld_data = '0;
  logic       z_alu_ready, z_ld_ready, z_rf_we, z_fwd_hit, z_wb_idle;
  logic [2:0] z_rf_reg;
  logic [7:0] z_rf_data, z_fwd_data;
  logic [2:0] z_wb_count;

  always #5 clk = ~clk;

  reg_writeback_ctrl #(.DEPTH(DEPTH), .R0_DISCARD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(alu_valid), .i_alu_reg(alu_reg), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
    .i_ld_valid(ld_valid), .i_ld_reg(ld_reg), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .o_rf_write_enable(rf_we), .o_rf_write_reg(rf_reg), .o_rf_write_data(rf_data),
    .i_fwd_reg(fwd_reg), .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data),
    .o_wb_count(wb_count), .o_wb_idle(wb_idle)
  );

  reg_writeback_ctrl #(.DEPTH(DEPTH), .R0_DISCARD(1'b1)) dut_r0 (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(z_alu_valid), .i_alu_reg(z_alu_reg), .i_alu_data(z_alu_data), .o_alu_ready(z_alu_ready),
    .i_ld_valid(z_ld_valid), .i_ld_reg(z_ld_reg), .i_ld_data(z_ld_data), .o_ld_ready(z_ld_ready),
    .o_rf_write_enable(z_rf_we), .o_rf_write_reg(z_rf_reg), .o_rf_write_data(z_rf_data),
    .i_fwd_reg(z_fwd_reg), .o_fwd_hit(z_fwd_hit), .o_fwd_data(z_fwd_data),
    .o_wb_count(z_wb_count), .o_wb_idle(z_wb_idle)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
  } ent_t;

  ent_t       pend[$];
  bit         st_v = 1'b0;
  logic [2:0] st_reg = '0;
  logic [7:0] st_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs straight from the pending-write list and write stage.
  task automatic check_all(input string ctx);
    bit         hit;
    logic [7:0] fdat;
    hit  = 1'b0;
    fdat = 8'h00;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (!hit && pend[i].rd == fwd_reg) begin
        hit  = 1'b1;
        fdat = pend[i].data;
      end
    end
    if (!hit && st_v && st_reg == fwd_reg) begin
      hit  = 1'b1;
      fdat = st_data;
    end
    chk({ctx, ".count"},     wb_count,  pend.size());
    chk({ctx, ".alu_ready"}, alu_ready, pend.size() < DEPTH);
    chk({ctx, ".ld_ready"},  ld_ready,  (pend.size() < DEPTH) && !alu_valid);
    chk({ctx, ".rf_we"},     rf_we,     st_v);
    chk({ctx, ".rf_reg"},    rf_reg,    st_reg);
    chk({ctx, ".rf_data"},   rf_data,   st_data);
    chk({ctx, ".idle"},      wb_idle,   (pend.size() == 0) && !st_v);
    chk({ctx, ".fwd_hit"},   fwd_hit,   hit);
    chk({ctx, ".fwd_data"},  fwd_data,  fdat);
  endtask

  // Effect of the coming clock edge: oldest pending write moves to the port, accepted request joins.
  task automatic advance();
    bit   fire;
    ent_t e;
    fire = 1'b0;
    if (alu_valid && pend.size() < DEPTH) begin
      fire = 1'b1; e.rd = alu_reg; e.data = alu_data;
    end else if (ld_valid && pend.size() < DEPTH) begin
      fire = 1'b1; e.rd = ld_reg; e.data = ld_data;
    end
    if (pend.size() > 0) begin
      ent_t h;
      h = pend.pop_front();
      st_v = 1'b1; st_reg = h.rd; st_data = h.data;
    end else begin
      st_v = 1'b0;
    end
    if (fire) pend.push_back(e);
  endtask

  task automatic step(input logic av, input logic [2:0] ar, input logic [7:0] ad,
                      input logic lv, input logic [2:0] lr, input logic [7:0] ld,
                      input logic [2:0] fr, input string ctx);
    @(posedge clk);
    #1;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    ld_valid = lv; ld_reg = lr; ld_data = ld;
    fwd_reg = fr;
    #3;
    check_all(ctx);
    advance();
  endtask

  task automatic idle(input logic [2:0] fr, input string ctx);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, fr, ctx);
  endtask

  task automatic do_reset(input string ctx);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    alu_valid = 1'b0; ld_valid = 1'b0;
    #1;
    chk({ctx, ".rst_rf_we"}, rf_we,    1'b0);
    chk({ctx, ".rst_count"}, wb_count, 3'd0);
    chk({ctx, ".rst_idle"},  wb_idle,  1'b1);
    chk({ctx, ".rst_fwd"},   fwd_hit,  1'b0);
    pend.delete();
    st_v = 1'b0; st_reg = '0; st_data = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset("init");

    // Single ALU write: strobe two cycles after acceptance, idle one cycle later.
    step(1'b1, 3'd1, 8'hAA, 1'b0, 3'd0, 8'h00, 3'd1, "t1_n");
    idle(3'd1, "t1_n1");
    idle(3'd1, "t1_n2");
    chk("t1_n2.we",   rf_we,   1'b1);
    chk("t1_n2.reg",  rf_reg,  3'd1);
    chk("t1_n2.data", rf_data, 8'hAA);
    idle(3'd1, "t1_n3");
    chk("t1_n3.we",   rf_we,   1'b0);
    chk("t1_n3.idle", wb_idle, 1'b1);

    // ALU and load together: ALU wins, load goes next cycle, writes in order.
    step(1'b1, 3'd2, 8'hF0, 1'b1, 3'd3, 8'h0F, 3'd2, "t2_both");
    chk("t2_both.ld_ready", ld_ready, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h0F, 3'd3, "t2_ld");
    chk("t2_ld.ld_ready", ld_ready, 1'b1);
    idle(3'd3, "t2_w2");
    chk("t2_w2.reg",  rf_reg,  3'd2);
    chk("t2_w2.data", rf_data, 8'hF0);
    idle(3'd3, "t2_w3");
    chk("t2_w3.reg",  rf_reg,  3'd3);
    chk("t2_w3.data", rf_data, 8'h0F);
    idle(3'd0, "t2_end");

    // Five back-to-back ALU requests.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'(i + 1), 8'(8'h10 + i), 1'b0, 3'd0, 8'h00, 3'(i), $sformatf("t3_req%0d", i));
    end
    for (int i = 0; i < 3; i++) idle(3'd5, $sformatf("t3_drain%0d", i));

    // Duplicate destination: youngest pending value is forwarded.
    step(1'b1, 3'd4, 8'h11, 1'b0, 3'd0, 8'h00, 3'd4, "t4_a");
    step(1'b1, 3'd4, 8'h22, 1'b0, 3'd0, 8'h00, 3'd4, "t4_b");
    idle(3'd4, "t4_c");
    chk("t4_c.hit",  fwd_hit,  1'b1);
    chk("t4_c.data", fwd_data, 8'h22);
    idle(3'd4, "t4_d");
    idle(3'd4, "t4_e");
    chk("t4_e.hit",  fwd_hit,  1'b0);
    chk("t4_e.data", fwd_data, 8'h00);

    // Reset while a write is on the port and another is queued.
    step(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00, 3'd6, "t5_a");
    step(1'b1, 3'd7, 8'h77, 1'b0, 3'd0, 8'h00, 3'd7, "t5_b");
    do_reset("t5");
    for (int i = 0; i < 3; i++) begin
      idle(3'd7, $sformatf("t5_post%0d", i));
      chk($sformatf("t5_post%0d.we", i), rf_we, 1'b0);
    end

    // R0 discard instance: r0 request accepted but never written; r5 still flows.
    @(posedge clk);
    #1;
    z_alu_valid = 1'b1; z_alu_reg = 3'd0; z_alu_data = 8'h55; z_fwd_reg = 3'd0;
    #3;
    chk("t6_r0.ready", z_alu_ready, 1'b1);
    chk("t6_r0.count", z_wb_count,  3'd0);
    @(posedge clk);
    #1;
    z_alu_valid = 1'b0;
    #3;
    chk("t6_n1.count", z_wb_count, 3'd0);
    chk("t6_n1.fwd",   z_fwd_hit,  1'b0);
    @(posedge clk);
    #4;
    chk("t6_n2.we",   z_rf_we,   1'b0);
    chk("t6_n2.idle", z_wb_idle, 1'b1);
    @(posedge clk);
    #1;
    z_alu_valid = 1'b1; z_alu_reg = 3'd5; z_alu_data = 8'h5A;
    @(posedge clk);
    #1;
    z_alu_valid = 1'b0;
    #3;
    chk("t6_r5.count", z_wb_count, 3'd1);
    @(posedge clk);
    #4;
    chk("t6_r5.we",   z_rf_we,   1'b1);
    chk("t6_r5.reg",  z_rf_reg,  3'd5);
    chk("t6_r5.data", z_rf_data, 8'h5A);
    // Keep the main bench model aligned across the edges spent above.
    pend.delete();
    st_v = 1'b0;

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset($sformatf("rnd%0d", n));
      end else begin
        step(1'($urandom_range(0, 99) < 55), 3'($urandom), 8'($urandom),
             1'($urandom_range(0, 99) < 55), 3'($urandom), 8'($urandom),
             3'($urandom), $sformatf("rnd%0d", n));
      end
    end
    for (int i = 0; i < 3; i++) idle(3'd0, $sformatf("final%0d", i));
    chk("final.idle", wb_idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
